uart_ctrl_regs: RTL and testbench
=================================

Name: uart_ctrl_regs

Overview:
CPU-facing register front end that drives the byte-level UART core.
- Accepts CPU writes into a TX FIFO and drains it into the core's tx_ena/tx_data/tx_busy handshake.
- Captures the core's rx_data_valid pulses into an RX FIFO that the CPU pops by reading.
- Sits between the RISC-V memory bus decoder and the uart instance; raises an interrupt line.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of two, minimum 2
RX_DEPTH, 16, RX FIFO entries; power of two, minimum 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
mem_valid  in  1  bus request, held until mem_ready
mem_addr  in  4  byte offset within the block
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; all zero means read
mem_rdata  out  32  read data, valid while mem_ready=1
mem_ready  out  1  single-cycle completion pulse
uart_tx_ena  out  1  one-cycle start pulse to the core
uart_tx_data  out  8  byte to transmit
uart_tx_busy  in  1  core transmitter busy
uart_rx_data  in  8  received byte
uart_rx_valid  in  1  one-cycle received-byte pulse
uart_rx_error  in  1  framing/parity error for the current byte
irq  out  1  level interrupt

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - mem_ready=0, mem_rdata=0, uart_tx_ena=0, uart_tx_data=0, irq=0.
  - Both FIFOs empty, sticky flags 0, CTRL=0, TX FSM in IDLE.
- Register map:
  - 0x0 DATA
    - Write with wstrb[0]=1 pushes wdata[7:0] into the TX FIFO.
    - Read pops the RX FIFO and returns {rx_was_empty, 23'b0, byte}.
    - If the RX FIFO is empty, the read returns 0x8000_0000 and does not pop.
  - 0x4 STATUS
    - Read returns: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 rx_overrun, bit5 rx_frame_err, bits[15:8] rx_count (zero-extended).
    - Write is W1C on bits 4 and 5.
  - 0x8 CTRL (R/W): bit0 rx_ie, bit1 tx_ie.
  - Other offsets: reads return 0, writes are ignored, mem_ready still pulses.
- Bus handshake:
  - mem_ready <= mem_valid & ~mem_ready & ~stall, so a request completes no earlier than one cycle after mem_valid rises.
  - The pop, push or register update happens on the same edge that raises mem_ready.
  - mem_rdata is registered on that edge.
  - Back-to-back requests are legal; mem_ready is never high two consecutive cycles.
- stall: a DATA write while the TX FIFO is full. mem_ready is withheld until an entry frees. No data is dropped.
- TX drain FSM:
  - IDLE → LAUNCH when TX FIFO not empty and uart_tx_busy=0.
  - LAUNCH (1 cycle): uart_tx_ena=1, uart_tx_data=head, pop → WAIT_BUSY.
  - WAIT_BUSY: wait for uart_tx_busy=1 → WAIT_DONE.
  - WAIT_DONE: wait for uart_tx_busy=0 → IDLE.
  - Minimum gap between tx_ena pulses is therefore one full core frame.
- RX capture:
  - uart_rx_valid pushes uart_rx_data.
  - If uart_rx_error=1, the byte is still pushed and rx_frame_err is set.
  - If the FIFO is full and no CPU pop occurs that cycle, the byte is dropped and rx_overrun is set.
- Simultaneous events:
  - RX push and CPU pop on the same edge with the FIFO full: both happen, no overrun, count unchanged.
  - Push on an empty FIFO with a same-edge read: the read reports empty; the byte is stored.
  - TX push and FSM pop on the same edge: both happen.
  - A sticky flag set and its W1C on the same edge: set wins.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Count = wr_ptr − rd_ptr (modulo).
- irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty), registered (one-cycle lag).
- Reset mid-operation:
  - FIFOs flush and the FSM returns to IDLE.
  - A frame already inside the core completes on its own.
  - The FSM will not launch again until uart_tx_busy=0.
  - A pending bus request is dropped; the CPU must reissue.

Decomposition:
- Shared package holds:
  - register offsets (DATA 0x0, STATUS 0x4, CTRL 0x8);
  - STATUS/CTRL bit indices;
  - TX FSM state encodings (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - the RX-empty flag bit position (31).
- One sub-module is natural: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). It is instantiated twice.

Test Plan:
- Write DATA 0x41, 0x42, 0x43 with a core model holding busy for 100 cycles per frame → exactly three uart_tx_ena pulses carrying 0x41, 0x42, 0x43 in order, each at least 100 cycles apart; STATUS bit1 returns to 1.
- Write 17 bytes with TX_DEPTH=16 while the core stays busy → the 17th write stalls (no mem_ready) until the first pop, then completes; no byte is lost.
- Inject 0x55, then 0xAA with uart_rx_error=1 → DATA reads return 0x0000_0055, then 0x0000_00AA; STATUS bit5=1; a third read returns 0x8000_0000.
- Inject 17 bytes with no reads → rx_count=16 and STATUS bit4=1; writing STATUS 0x30 clears bits 4 and 5; a W1C landing on the same edge as a new overrun leaves bit4=1.
- With the RX FIFO full, a read pop on the same edge as an RX push → no overrun, rx_count stays 16, ordering is preserved.
- Set CTRL=0x1 and inject one byte → irq rises within 2 cycles and falls after the DATA read; assert reset mid-drain → FIFOs empty and no uart_tx_ena until uart_tx_busy=0.

Source files
------------

// File: rtl/uart_ctrl_regs_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_regs_pkg
// Purpose : shared definitions for the UART register front end: register
//           offsets, STATUS/CTRL bit positions, and TX drain FSM encodings.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package uart_ctrl_regs_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_RX_FRAME_ERR = 5;
  localparam int ST_RX_COUNT_LSB = 8;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  // Set in a DATA read result when the RX FIFO had nothing to give.
  localparam int RX_EMPTY_FLAG_BIT = 31;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LAUNCH    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_ctrl_regs_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : single-clock FIFO with show-ahead output (dout is the head entry).
// Ports   : clk, reset (sync, active-high)
//           push/din  - write an entry; accepted when not full, or when full
//                       and a pop happens on the same edge
//           pop/dout  - remove head entry; ignored when empty
//           full, empty, count - occupancy status
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty; subtraction wraps.
  assign count     = r_wr_ptr - r_rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_ctrl_regs.sv
// -----------------------------------------------------------------------------
// uart_ctrl_regs
// Purpose : CPU register front end for the byte-level UART core. CPU writes
//           fill a TX FIFO that is drained into the core one frame at a time;
//           received bytes are queued in an RX FIFO that CPU reads pop.
// Ports   : clk, reset (sync, active-high)
//           mem_valid/mem_addr/mem_wdata/mem_wstrb - bus request (wstrb=0 read)
//           mem_rdata/mem_ready                    - registered completion
//           uart_tx_ena/uart_tx_data/uart_tx_busy  - core transmit handshake
//           uart_rx_data/uart_rx_valid/uart_rx_error - core receive strobe
//           irq                                     - level interrupt
//
// TX drain FSM
//   state        | meaning
//   TX_IDLE      | wait for a queued byte and an idle core
//   TX_LAUNCH    | one-cycle tx_ena with the FIFO head, pop it
//   TX_WAIT_BUSY | wait for the core to acknowledge with busy=1
//   TX_WAIT_DONE | wait for the core frame to finish (busy=0)
// -----------------------------------------------------------------------------
module uart_ctrl_regs
  import uart_ctrl_regs_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        uart_tx_ena,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  input  logic        uart_rx_error,
  output logic        irq
);

  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;
  logic        r_rx_overrun;
  logic        r_rx_frame_err;
  logic        r_rx_ie;
  logic        r_tx_ie;
  logic        r_irq;
  tx_state_t   r_tx_state;
  tx_state_t   w_tx_next;

  logic        w_tx_full, w_tx_empty, w_tx_pop;
  logic [7:0]  w_tx_head;
  logic [$clog2(TX_DEPTH):0] w_tx_count;
  logic        w_rx_full, w_rx_empty;
  logic [7:0]  w_rx_head;
  logic [$clog2(RX_DEPTH):0] w_rx_count;

  logic        w_req, w_is_wr, w_sel_data, w_sel_status, w_sel_ctrl;
  logic        w_tx_wr, w_stall, w_fire, w_tx_push, w_rx_pop;
  logic        w_st_wr, w_ctrl_wr, w_ovr_set, w_err_set, w_ovr_clr, w_err_clr;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  // ---------------------------------------------------------------- bus decode
  assign w_req        = mem_valid & ~r_mem_ready;
  assign w_is_wr      = |mem_wstrb;
  assign w_sel_data   = (mem_addr == ADDR_DATA);
  assign w_sel_status = (mem_addr == ADDR_STATUS);
  assign w_sel_ctrl   = (mem_addr == ADDR_CTRL);

  assign w_tx_wr   = w_req & w_is_wr & w_sel_data & mem_wstrb[0];
  // A pop by the drain FSM on this edge makes room, so no stall then.
  assign w_stall   = w_tx_wr & w_tx_full & ~w_tx_pop;
  assign w_fire    = w_req & ~w_stall;
  assign w_tx_push = w_fire & w_tx_wr;
  assign w_rx_pop  = w_fire & ~w_is_wr & w_sel_data & ~w_rx_empty;
  assign w_st_wr   = w_fire & w_is_wr & w_sel_status & mem_wstrb[0];
  assign w_ctrl_wr = w_fire & w_is_wr & w_sel_ctrl & mem_wstrb[0];

  assign w_ovr_set = uart_rx_valid & w_rx_full & ~w_rx_pop;
  assign w_err_set = uart_rx_valid & uart_rx_error;
  assign w_ovr_clr = w_st_wr & mem_wdata[ST_RX_OVERRUN];
  assign w_err_clr = w_st_wr & mem_wdata[ST_RX_FRAME_ERR];

  assign w_unused = ^{mem_wdata, w_tx_count};

  always_comb begin
    w_status = '0;
    w_status[ST_TX_FULL]      = w_tx_full;
    w_status[ST_TX_EMPTY]     = w_tx_empty;
    w_status[ST_RX_EMPTY]     = w_rx_empty;
    w_status[ST_RX_FULL]      = w_rx_full;
    w_status[ST_RX_OVERRUN]   = r_rx_overrun;
    w_status[ST_RX_FRAME_ERR] = r_rx_frame_err;
    w_status[ST_RX_COUNT_LSB +: 8] = 8'(w_rx_count);
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_data) begin
      if (w_rx_empty) w_rdata[RX_EMPTY_FLAG_BIT] = 1'b1;
      else            w_rdata[7:0] = w_rx_head;
    end else if (w_sel_status) begin
      w_rdata = w_status;
    end else if (w_sel_ctrl) begin
      w_rdata[CTRL_RX_IE] = r_rx_ie;
      w_rdata[CTRL_TX_IE] = r_tx_ie;
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_ready    <= 1'b0;
      r_mem_rdata    <= '0;
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_rx_ie        <= 1'b0;
      r_tx_ie        <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_mem_ready    <= w_fire;
      r_mem_rdata    <= (w_fire & ~w_is_wr) ? w_rdata : '0;
      // Set has priority over a same-edge write-one-to-clear.
      r_rx_overrun   <= w_ovr_set | (r_rx_overrun & ~w_ovr_clr);
      r_rx_frame_err <= w_err_set | (r_rx_frame_err & ~w_err_clr);
      if (w_ctrl_wr) begin
        r_rx_ie <= mem_wdata[CTRL_RX_IE];
        r_tx_ie <= mem_wdata[CTRL_TX_IE];
      end
      r_irq <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty);
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign irq       = r_irq;

  // ------------------------------------------------------------ TX drain FSM
  always_ff @(posedge clk) begin
    if (reset) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      TX_IDLE:      if (~w_tx_empty & ~uart_tx_busy) w_tx_next = TX_LAUNCH;
      TX_LAUNCH:    w_tx_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (uart_tx_busy)  w_tx_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (~uart_tx_busy) w_tx_next = TX_IDLE;
      default:      w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_tx_ena  = 1'b0;
    uart_tx_data = '0;
    w_tx_pop     = 1'b0;
    if (r_tx_state == TX_LAUNCH) begin
      uart_tx_ena  = 1'b1;
      uart_tx_data = w_tx_head;
      w_tx_pop     = 1'b1;
    end
  end

  // ------------------------------------------------------------ FIFOs
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (mem_wdata[7:0]),
    .dout  (w_tx_head),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (uart_rx_valid),
    .pop   (w_rx_pop),
    .din   (uart_rx_data),
    .dout  (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

endmodule

// File: tb/tb_uart_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_uart_ctrl_regs
// Purpose : directed self-checking bench for uart_ctrl_regs with a simple
//           UART core model that holds busy for 100 cycles per frame.
// -----------------------------------------------------------------------------
module tb_uart_ctrl_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        uart_tx_ena;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_error;
  logic        irq;

  always #5 clk = ~clk;

  uart_ctrl_regs #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .uart_tx_ena   (uart_tx_ena),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_error (uart_rx_error),
    .irq           (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Core model and TX monitor, both evaluated away from the active edge.
  logic       model_busy = 1'b0;
  logic       hold_busy  = 1'b0;
  int         model_cnt  = 0;
  int         cyc        = 0;
  int         ena_while_busy = 0;
  logic [7:0] tx_q[$];
  int         tx_t[$];

  assign uart_tx_busy = model_busy | hold_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_tx_ena) begin
      tx_q.push_back(uart_tx_data);
      tx_t.push_back(cyc);
      if (uart_tx_busy) ena_while_busy++;
      model_busy = 1'b1;
      model_cnt  = 100;
    end else if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) model_busy = 1'b0;
    end
  end

  task automatic bus(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_ready) break;
    end
    check("bus_ready", {31'b0, mem_ready}, 32'd1);
    rd        = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, d, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(a, 32'h0, 4'h0, v);
    check(tag, v, exp);
  endtask

  task automatic inject(input logic [7:0] b, input logic err);
    uart_rx_data  = b;
    uart_rx_error = err;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    uart_rx_error = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (tx_q.size() >= n && !uart_tx_busy) break;
      @(negedge clk);
    end
    check("tx_launch_count", tx_q.size(), n);
  endtask

  initial begin
    int seen;
    reset = 1'b1; mem_valid = 1'b0; mem_addr = 4'h0; mem_wdata = '0; mem_wstrb = 4'h0;
    uart_rx_data = 8'h0; uart_rx_valid = 1'b0; uart_rx_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_tx_ena", {31'b0, uart_tx_ena}, 32'd0);
    check("rst_tx_data", {24'b0, uart_tx_data}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rd_chk("rst_status", 4'h4, 32'h0000_0006);
    rd_chk("rst_ctrl", 4'h8, 32'h0);
    rd_chk("other_rd", 4'hC, 32'h0);
    wr(4'hC, 32'hFFFF_FFFF);
    rd_chk("other_wr_ignored", 4'h8, 32'h0);

    // Three bytes through the core model.
    wr(4'h0, 32'h41); wr(4'h0, 32'h42); wr(4'h0, 32'h43);
    wait_launches(3, 1000);
    if (tx_q.size() == 3) begin
      check("tx_byte0", {24'b0, tx_q[0]}, 32'h41);
      check("tx_byte1", {24'b0, tx_q[1]}, 32'h42);
      check("tx_byte2", {24'b0, tx_q[2]}, 32'h43);
      check("tx_gap01", {31'b0, (tx_t[1] - tx_t[0]) >= 100}, 32'd1);
      check("tx_gap12", {31'b0, (tx_t[2] - tx_t[1]) >= 100}, 32'd1);
    end
    rd_chk("tx_empty_after", 4'h4, 32'h0000_0006);
    tx_q.delete(); tx_t.delete();

    // Fill TX FIFO while the core is held busy; 17th write must stall.
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(4'h0, 32'h60 + i);
    rd_chk("tx_full_status", 4'h4, 32'h0000_0005);
    mem_addr = 4'h0; mem_wdata = 32'h70; mem_wstrb = 4'h1; mem_valid = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_ready) seen++;
    end
    check("stall_hold", seen, 0);
    hold_busy = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_ready) break;
    end
    check("stall_release", {31'b0, mem_ready}, 32'd1);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    wait_launches(17, 3000);
    if (tx_q.size() == 17) begin
      for (int i = 0; i < 17; i++)
        check("stall_order", {24'b0, tx_q[i]}, (i < 16) ? 32'h60 + i : 32'h70);
    end
    check("ena_while_busy", ena_while_busy, 0);
    tx_q.delete(); tx_t.delete();

    // RX basic path and frame error.
    inject(8'h55, 1'b0);
    inject(8'hAA, 1'b1);
    rd_chk("rx_byte55", 4'h0, 32'h0000_0055);
    rd_chk("rx_byteAA", 4'h0, 32'h0000_00AA);
    rd_chk("rx_frame_err", 4'h4, 32'h0000_0026);
    rd_chk("rx_empty_read", 4'h0, 32'h8000_0000);
    wr(4'h4, 32'h30);
    rd_chk("frame_err_clr", 4'h4, 32'h0000_0006);

    // Overrun and W1C.
    for (int i = 0; i < 17; i++) inject(8'h10 + 8'(i), 1'b0);
    rd_chk("ovr_status", 4'h4, 32'h0000_101A);
    wr(4'h4, 32'h30);
    rd_chk("ovr_clr", 4'h4, 32'h0000_100A);
    @(negedge clk);
    mem_addr = 4'h4; mem_wdata = 32'h30; mem_wstrb = 4'hF; mem_valid = 1'b1;
    uart_rx_data = 8'h99; uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    check("w1c_collide_ready", {31'b0, mem_ready}, 32'd1);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    rd_chk("set_wins_w1c", 4'h4, 32'h0000_101A);
    wr(4'h4, 32'h30);
    rd_chk("ovr_clr2", 4'h4, 32'h0000_100A);

    // Pop and push on the same edge with the RX FIFO full.
    @(negedge clk);
    mem_addr = 4'h0; mem_wstrb = 4'h0; mem_valid = 1'b1;
    uart_rx_data = 8'h77; uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    check("popush_ready", {31'b0, mem_ready}, 32'd1);
    check("popush_data", mem_rdata, 32'h0000_0010);
    mem_valid = 1'b0;
    rd_chk("popush_status", 4'h4, 32'h0000_100A);
    for (int i = 1; i < 16; i++) rd_chk("popush_order", 4'h0, 32'h10 + i);
    rd_chk("popush_last", 4'h0, 32'h0000_0077);
    rd_chk("popush_empty", 4'h0, 32'h8000_0000);

    // Interrupts.
    wr(4'h8, 32'h1);
    rd_chk("ctrl_rb", 4'h8, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_idle", {31'b0, irq}, 32'd0);
    inject(8'h5A, 1'b0);
    @(negedge clk);
    check("irq_rx_rise", {31'b0, irq}, 32'd1);
    rd_chk("irq_rx_byte", 4'h0, 32'h0000_005A);
    repeat (2) @(negedge clk);
    check("irq_rx_fall", {31'b0, irq}, 32'd0);
    wr(4'h8, 32'h2);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", {31'b0, irq}, 32'd1);
    wr(4'h8, 32'h0);
    repeat (2) @(negedge clk);
    check("irq_off", {31'b0, irq}, 32'd0);

    // Reset while draining; the in-flight frame finishes on its own.
    wr(4'h0, 32'hC1); wr(4'h0, 32'hC2); wr(4'h0, 32'hC3);
    for (int k = 0; k < 50; k++) begin
      if (tx_q.size() >= 1) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_chk("rst_mid_status", 4'h4, 32'h0000_0006);
    wr(4'h0, 32'hD1);
    for (int k = 0; k < 200; k++) begin
      if (!uart_tx_busy) break;
      @(negedge clk);
    end
    check("rst_no_launch_busy", tx_q.size(), 1);
    for (int k = 0; k < 20; k++) begin
      if (tx_q.size() >= 2) break;
      @(negedge clk);
    end
    check("rst_relaunch_cnt", tx_q.size(), 2);
    if (tx_q.size() >= 2) check("rst_relaunch_byte", {24'b0, tx_q[1]}, 32'hD1);
    check("ena_while_busy_end", ena_while_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
